// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store bus master.
// LSU_SUBWORD_EN selects whether byte/halfword accesses are legal.
package lsu_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    // An access the bus master refuses to issue; it completes with an error and no bus cycle.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
`ifdef LSU_SUBWORD_EN
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return addr_lo[0];
            SZ_W:    return addr_lo != 2'b00;
            default: return 1'b1;
        endcase
`else
        return (size != SZ_W) || (addr_lo != 2'b00);
`endif
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Sub-word lane handling: load extract with sign/zero extension, and store merge.
// Instantiated only when LSU_SUBWORD_EN is defined.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [WORD_W-1:0] rd_word_i,
    input  logic [WORD_W-1:0] mrg_word_i,
    input  logic [1:0]        addr_lo_i,
    input  logic [1:0]        size_i,
    input  logic              sext_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] load_o,
    output logic [WORD_W-1:0] merge_o
);

    logic [WORD_W-1:0] shifted;
    logic [WORD_W-1:0] lane_mask;
    logic [WORD_W-1:0] lane_data;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;

    always_comb begin
        // Aligned halfwords only occur at lane 0 or 2, so the byte shift also lands them.
        shifted = rd_word_i >> {addr_lo_i, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = shifted[15:0];

        case (size_i)
            SZ_B:    load_o = {{24{sext_i & byte_v[7]}}, byte_v};
            SZ_H:    load_o = {{16{sext_i & half_v[15]}}, half_v};
            default: load_o = rd_word_i;
        endcase

        case (size_i)
            SZ_B: begin
                lane_mask = 32'h0000_00FF << {addr_lo_i, 3'b000};
                lane_data = {24'h0, wdata_i[7:0]} << {addr_lo_i, 3'b000};
            end
            SZ_H: begin
                lane_mask = 32'h0000_FFFF << {addr_lo_i[1], 4'b0000};
                lane_data = {16'h0, wdata_i[15:0]} << {addr_lo_i[1], 4'b0000};
            end
            default: begin
                lane_mask = '1;
                lane_data = wdata_i;
            end
        endcase

        merge_o = (mrg_word_i & ~lane_mask) | (lane_data & lane_mask);
    end

endmodule

// File: rtl/lsu_bus_master.sv
// Single-outstanding load/store initiator issuing word-only bus cycles.
// Define LSU_SUBWORD_EN for byte/halfword support (read-modify-write stores).
module lsu_bus_master
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              sext_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    output logic              ready_o,
    output logic              stall_o,
    output logic              done_o,
    output logic              err_o,
    output logic [31:0]       rdata_o,
    output logic              bus_wen_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [31:0]       bus_wdata_o,
    input  logic [31:0]       bus_rdata_i
);

    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              sext_q, sext_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [WORD_W-1:0] load_val;
    logic [WORD_W-1:0] store_val;
    logic [ADDR_W-1:0] word_addr;
    logic              unused_addr;

    assign word_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    assign unused_addr = ^addr_i[31:ADDR_W];

`ifdef LSU_SUBWORD_EN
    lsu_align u_align (
        .rd_word_i  (bus_rdata_i),
        .mrg_word_i (word_q),
        .addr_lo_i  (addr_q[1:0]),
        .size_i     (size_q),
        .sext_i     (sext_q),
        .wdata_i    (wdata_q),
        .load_o     (load_val),
        .merge_o    (store_val)
    );
`else
    logic unused_cfg;
    assign load_val   = bus_rdata_i;
    assign store_val  = wdata_q;
    assign unused_cfg = ^{size_q, sext_q, addr_q[1:0], word_q};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= '0;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        sext_d      = sext_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        word_d      = word_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        ready_o     = 1'b0;
        stall_o     = 1'b0;
        done_o      = 1'b0;
        bus_wen_o   = 1'b0;
        bus_addr_o  = '0;
        bus_wdata_o = '0;

        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                stall_o = req_i;
                if (req_i) begin
                    we_d    = we_i;
                    size_d  = size_i;
                    sext_d  = sext_i;
                    addr_d  = addr_i[ADDR_W-1:0];
                    wdata_d = wdata_i;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (misaligned(size_i, addr_i[1:0])) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (!we_i || size_i != SZ_W) begin
                        state_d = RD;
                    end else begin
                        state_d = WR;
                    end
                end
            end
            RD: begin
                stall_o    = 1'b1;
                bus_addr_o = word_addr;
                word_d     = bus_rdata_i;
                if (we_q) begin
                    state_d = WR;
                end else begin
                    rdata_d = load_val;
                    state_d = DONE;
                end
            end
            WR: begin
                stall_o     = 1'b1;
                bus_wen_o   = 1'b1;
                bus_addr_o  = word_addr;
                bus_wdata_o = store_val;
                state_d     = DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rdata_o = rdata_q;
    assign err_o   = err_q;

endmodule
